// File: rtl/dac_spi_pkg.sv
// Shared types and frame packing for the multi-channel DAC121S101-class SPI transmitter.
package dac_spi_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      GAP
   } state_e;

   typedef enum logic [1:0] {
      PD_NORMAL = 2'b00,
      PD_1K     = 2'b01,
      PD_100K   = 2'b10,
      PD_HIZ    = 2'b11
   } pd_e;

   localparam int MAX_FRAME_W = 32;

   // Frame is right-aligned in the result: 2'b00, pd, then the sample left-justified
   // directly below the pd bits with zero padding underneath.
   function automatic logic [MAX_FRAME_W-1:0] frame_pack(
      input logic [MAX_FRAME_W-1:0] data,
      input pd_e                    pd,
      input int                     data_w,
      input int                     frame_w
   );
      logic [MAX_FRAME_W-1:0] hdr;
      hdr = {{(MAX_FRAME_W-2){1'b0}}, pd};
      return (hdr << (frame_w - 4)) | (data << (frame_w - 4 - data_w));
   endfunction

endpackage

// File: rtl/dac_sclk_gen.sv
// SCLK generator: half-period counter and toggle register, parked high while not running.
module dac_sclk_gen #(
   parameter int SCLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic sclk,
   output logic fall_stb,
   output logic rise_stb
);

   localparam int CNT_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCLK_DIV - 1);

   logic [CNT_W-1:0] cnt;
   logic             wrap;

   // Strobes flag the cycle whose closing edge moves sclk to its new level.
   assign wrap     = run && (cnt == CNT_MAX);
   assign fall_stb = wrap && sclk;
   assign rise_stb = wrap && !sclk;

   always_ff @(posedge clk) begin
      if (rst || !run) begin
         cnt  <= '0;
         sclk <= 1'b1;
      end else if (wrap) begin
         cnt  <= '0;
         sclk <= ~sclk;
      end else begin
         cnt  <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/pmod_dac_spi_tx.sv
// Multi-channel DAC121S101-class SPI transmitter with a valid/ready sample port.
// All channels share sclk/nsync; one frame updates every channel at once.
module pmod_dac_spi_tx
   import dac_spi_pkg::*;
#(
   parameter int NUM_CH   = 2,
   parameter int DATA_W   = 12,
   parameter int FRAME_W  = 16,
   parameter int SCLK_DIV = 2,
   parameter int GAP_CYC  = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [NUM_CH*DATA_W-1:0] s_data,
   input  logic [1:0]               s_pd,
   output logic                     sclk,
   output logic                     nsync,
   output logic [NUM_CH-1:0]        sdo,
   output logic                     busy,
   output logic                     done
);

   localparam int BIT_W = $clog2(FRAME_W + 1);
   localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC + 1) : 1;

   if (DATA_W > FRAME_W - 4) begin : g_chk_data_w
      $error("DATA_W must not exceed FRAME_W-4");
   end
   if (SCLK_DIV < 1) begin : g_chk_sclk_div
      $error("SCLK_DIV must be at least 1");
   end
   if (NUM_CH < 1 || NUM_CH > 8) begin : g_chk_num_ch
      $error("NUM_CH must be in 1..8");
   end
   if (FRAME_W > MAX_FRAME_W || GAP_CYC < 0) begin : g_chk_frame
      $error("FRAME_W must not exceed MAX_FRAME_W and GAP_CYC must be >= 0");
   end

   state_e               state_q, state_d;
   logic [FRAME_W-1:0]   frame [NUM_CH];
   logic [FRAME_W-1:0]   sr_q  [NUM_CH];
   logic [FRAME_W-1:0]   sr_d  [NUM_CH];
   logic [NUM_CH-1:0]    sdo_d;
   logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
   logic                 nsync_d, ready_d, done_d, busy_d;
   logic                 sclk_fall, sclk_rise;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_pack
      assign frame[c] = FRAME_W'(frame_pack(MAX_FRAME_W'(s_data[c*DATA_W +: DATA_W]),
                                            pd_e'(s_pd), DATA_W, FRAME_W));
   end

   dac_sclk_gen #(
      .SCLK_DIV (SCLK_DIV)
   ) u_sclk_gen (
      .clk      (clk),
      .rst      (rst),
      .run      (state_q == SHIFT),
      .sclk     (sclk),
      .fall_stb (sclk_fall),
      .rise_stb (sclk_rise)
   );

   always_comb begin
      // NOTE: every next-state signal takes a default first, so no path leaves one unassigned and no latch is inferred.
      state_d   = state_q;
      sr_d      = sr_q;
      sdo_d     = sdo;
      nsync_d   = nsync;
      ready_d   = s_ready;
      done_d    = 1'b0;
      bit_cnt_d = bit_cnt_q;
      gap_cnt_d = gap_cnt_q;

      unique case (state_q)
         IDLE: begin
            if (s_valid && s_ready) begin
               state_d   = SHIFT;
               ready_d   = 1'b0;
               nsync_d   = 1'b0;
               bit_cnt_d = '0;
               for (int c = 0; c < NUM_CH; c++) begin
                  sdo_d[c] = frame[c][FRAME_W-1];
                  sr_d[c]  = frame[c] << 1;
               end
            end
         end
         SHIFT: begin
            // bit_cnt counts DAC sampling (falling) edges; the rise after the last one closes the frame.
            if (sclk_fall) bit_cnt_d = bit_cnt_q + 1'b1;
            if (sclk_rise) begin
               if (bit_cnt_q == BIT_W'(FRAME_W)) begin
                  nsync_d   = 1'b1;
                  sdo_d     = '0;
                  gap_cnt_d = '0;
                  if (GAP_CYC == 0) begin
                     state_d = IDLE;
                     ready_d = 1'b1;
                     done_d  = 1'b1;
                  end else begin
                     state_d = GAP;
                  end
               end else begin
                  for (int c = 0; c < NUM_CH; c++) begin
                     sdo_d[c] = sr_q[c][FRAME_W-1];
                     sr_d[c]  = sr_q[c] << 1;
                  end
               end
            end
         end
         GAP: begin
            if (gap_cnt_q == GAP_W'(GAP_CYC - 1)) begin
               state_d = IDLE;
               ready_d = 1'b1;
               done_d  = 1'b1;
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         sdo       <= '0;
         nsync     <= 1'b1;
         s_ready   <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         sdo       <= sdo_d;
         nsync     <= nsync_d;
         s_ready   <= ready_d;
         busy      <= busy_d;
         done      <= done_d;
         bit_cnt_q <= bit_cnt_d;
         gap_cnt_q <= gap_cnt_d;
      end
   end

   // NOTE: the shift registers carry no reset; they are fully reloaded on every accept.
   always_ff @(posedge clk) begin
      sr_q <= sr_d;
   end

endmodule

// File: tb/tb_pmod_dac_spi_tx.sv
// Directed bench for pmod_dac_spi_tx: three configurations, frames captured on sclk falls.
module tb_pmod_dac_spi_tx;

   logic clk;
   logic rst;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_bad = 0;

   // A: defaults
   logic        a_valid, a_ready, a_sclk, a_nsync, a_busy, a_done;
   logic [23:0] a_data;
   logic [1:0]  a_pd, a_sdo;
   // B: NUM_CH=4, DATA_W=8, SCLK_DIV=3
   logic        b_valid, b_ready, b_sclk, b_nsync, b_busy, b_done;
   logic [31:0] b_data;
   logic [1:0]  b_pd;
   logic [3:0]  b_sdo;
   // C: SCLK_DIV=1, GAP_CYC=0
   logic        c_valid, c_ready, c_sclk, c_nsync, c_busy, c_done;
   logic [23:0] c_data;
   logic [1:0]  c_pd, c_sdo;

   pmod_dac_spi_tx u_dut_a (
      .clk(clk), .rst(rst), .s_valid(a_valid), .s_ready(a_ready), .s_data(a_data),
      .s_pd(a_pd), .sclk(a_sclk), .nsync(a_nsync), .sdo(a_sdo), .busy(a_busy), .done(a_done)
   );

   pmod_dac_spi_tx #(.NUM_CH(4), .DATA_W(8), .FRAME_W(16), .SCLK_DIV(3), .GAP_CYC(2)) u_dut_b (
      .clk(clk), .rst(rst), .s_valid(b_valid), .s_ready(b_ready), .s_data(b_data),
      .s_pd(b_pd), .sclk(b_sclk), .nsync(b_nsync), .sdo(b_sdo), .busy(b_busy), .done(b_done)
   );

   pmod_dac_spi_tx #(.NUM_CH(2), .DATA_W(12), .FRAME_W(16), .SCLK_DIV(1), .GAP_CYC(0)) u_dut_c (
      .clk(clk), .rst(rst), .s_valid(c_valid), .s_ready(c_ready), .s_data(c_data),
      .s_pd(c_pd), .sclk(c_sclk), .nsync(c_nsync), .sdo(c_sdo), .busy(c_busy), .done(c_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitors: shift sdo in on every sclk fall while nsync is low.
   logic [15:0] a_cap [2];
   logic [31:0] a_frm [16];
   logic        a_sclk_q = 1'b1, a_nsync_q = 1'b1;
   int a_falls = 0, a_low = 0, a_nfrm = 0, a_ndone = 0, a_done_cyc = 0;
   int a_rise_cyc = 0, a_high = 0;

   always @(negedge clk) begin
      if (a_nsync_q && !a_nsync) begin
         a_falls = 0;
         a_low   = 0;
         a_high  = cyc - a_rise_cyc;
      end
      if (!a_nsync_q && a_nsync) begin
         a_rise_cyc = cyc;
         if (a_falls == 16 && a_nfrm < 16) begin
            a_frm[a_nfrm] = {a_cap[1], a_cap[0]};
            a_nfrm++;
         end
      end
      if (!a_nsync) a_low++;
      if (a_sclk_q && !a_sclk && !a_nsync) begin
         for (int c = 0; c < 2; c++) a_cap[c] = {a_cap[c][14:0], a_sdo[c]};
         a_falls++;
      end
      if (a_done) begin
         a_ndone++;
         a_done_cyc = cyc;
      end
      a_sclk_q  = a_sclk;
      a_nsync_q = a_nsync;
   end

   logic [15:0] b_cap [4];
   logic        b_sclk_q = 1'b1, b_nsync_q = 1'b1;
   int b_falls = 0, b_low = 0, b_start = 0, b_first = 0, b_done_cyc = 0;

   always @(negedge clk) begin
      if (b_nsync_q && !b_nsync) begin
         b_falls = 0;
         b_low   = 0;
         b_start = cyc;
      end
      if (!b_nsync) b_low++;
      if (b_sclk_q && !b_sclk && !b_nsync) begin
         if (b_falls == 0) b_first = cyc - b_start;
         for (int c = 0; c < 4; c++) b_cap[c] = {b_cap[c][14:0], b_sdo[c]};
         b_falls++;
      end
      if (b_done) b_done_cyc = cyc;
      b_sclk_q  = b_sclk;
      b_nsync_q = b_nsync;
   end

   logic [15:0] c_cap [2];
   logic [31:0] c_frm [16];
   logic        c_sclk_q = 1'b1, c_nsync_q = 1'b1;
   int c_falls = 0, c_low = 0, c_nfrm = 0, c_start = 0, c_first = 0, c_done_cyc = 0;

   always @(negedge clk) begin
      if (c_nsync_q && !c_nsync) begin
         c_falls = 0;
         c_low   = 0;
         c_start = cyc;
      end
      if (!c_nsync_q && c_nsync && c_falls == 16 && c_nfrm < 16) begin
         c_frm[c_nfrm] = {c_cap[1], c_cap[0]};
         c_nfrm++;
      end
      if (!c_nsync) c_low++;
      if (c_sclk_q && !c_sclk && !c_nsync) begin
         if (c_falls == 0) c_first = cyc - c_start;
         for (int c = 0; c < 2; c++) c_cap[c] = {c_cap[c][14:0], c_sdo[c]};
         c_falls++;
      end
      if (c_done) c_done_cyc = cyc;
      c_sclk_q  = c_sclk;
      c_nsync_q = c_nsync;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send_a(input logic [23:0] d, input logic [1:0] pd, output int t);
      int n = 0;
      @(negedge clk);
      a_valid = 1'b1;
      a_data  = d;
      a_pd    = pd;
      while (!a_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("a_accept_timeout", 32'(n < 300), 32'd1);
      t = cyc;
      @(negedge clk);
      a_valid = 1'b0;
      a_data  = 24'hFFFFFF;
   endtask

   task automatic wait_done(input string tag, input int which);
      int n = 0;
      while (n < 400 && !((which == 0 && a_done) || (which == 1 && b_done) || (which == 2 && c_done))) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(n < 400), 32'd1);
      @(negedge clk);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, nd0, nf0, ka, kc, i, n;
      int acc [3];
      logic [23:0] b2b_d [3];
      logic [23:0] c_d [2];
      logic [1:0]  c_p [2];

      rst = 1'b1;
      a_valid = 1'b0; a_data = '0; a_pd = '0;
      b_valid = 1'b0; b_data = '0; b_pd = '0;
      c_valid = 1'b0; c_data = '0; c_pd = '0;
      repeat (3) @(negedge clk);
      check("reset_a", {a_sclk, a_nsync, a_sdo, a_busy, a_done, a_ready}, 32'b1100001);
      check("reset_b", {b_sclk, b_nsync, b_sdo, b_busy, b_done, b_ready}, 32'b110000001);
      check("reset_c", {c_sclk, c_nsync, c_sdo, c_busy, c_done, c_ready}, 32'b1100001);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Basic frame at defaults.
      ka  = a_nfrm;
      nd0 = a_ndone;
      send_a({12'hABC, 12'h123}, 2'b00, t);
      check("a_busy_in_frame", 32'(a_busy), 32'd1);
      wait_done("a1_done_timeout", 0);
      check("a1_frame", a_frm[ka], 32'h0ABC0123);
      check("a1_nsync_low", a_low, 32'd64);
      check("a1_falls", a_falls, 32'd16);
      check("a1_done_latency", a_done_cyc - t, 32'd67);
      check("a1_done_count", a_ndone - nd0, 32'd1);
      ka++;

      // Power-down codes with zero data.
      send_a(24'h000000, 2'b11, t);
      wait_done("a2_done_timeout", 0);
      check("a2_pd_hiz", a_frm[ka], 32'h30003000);
      ka++;
      send_a(24'h000000, 2'b01, t);
      wait_done("a3_done_timeout", 0);
      check("a3_pd_1k", a_frm[ka], 32'h10001000);
      ka++;

      // Back-to-back with s_valid held high; data scrambled while s_ready is low.
      b2b_d[0] = 24'h111222;
      b2b_d[1] = 24'h333444;
      b2b_d[2] = 24'h555666;
      i = 0;
      n = 0;
      @(negedge clk);
      a_valid = 1'b1;
      a_pd    = 2'b00;
      while (i < 3 && n < 400) begin
         if (a_ready) begin
            a_data = b2b_d[i];
            acc[i] = cyc;
            i++;
         end else begin
            a_data = 24'hFFFFFF;
         end
         @(negedge clk);
         n++;
      end
      a_valid = 1'b0;
      check("b2b_accept_timeout", 32'(i), 32'd3);
      wait_done("b2b_done_timeout", 0);
      check("b2b_period_1", acc[1] - acc[0], 32'd67);
      check("b2b_period_2", acc[2] - acc[1], 32'd67);
      check("b2b_frame_0", a_frm[ka], 32'h01110222);
      check("b2b_frame_1", a_frm[ka+1], 32'h03330444);
      check("b2b_frame_2", a_frm[ka+2], 32'h05550666);
      check("b2b_nsync_high", a_high, 32'd3);
      ka += 3;

      // Reset in the middle of a frame.
      send_a(24'h456789, 2'b00, t);
      n = 0;
      while (a_falls != 7 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("rst_bit7_timeout", 32'(n < 300), 32'd1);
      nd0 = a_ndone;
      nf0 = a_nfrm;
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_outputs", {a_sclk, a_nsync, a_sdo, a_busy, a_done, a_ready}, 32'b1100001);
      rst = 1'b0;
      repeat (80) @(negedge clk);
      check("rst_mid_no_done", a_ndone - nd0, 32'd0);
      check("rst_mid_no_frame", a_nfrm - nf0, 32'd0);
      send_a({12'h5A5, 12'hA5A}, 2'b10, t);
      wait_done("rst_after_done_timeout", 0);
      check("rst_after_frame", a_frm[ka], 32'h25A52A5A);
      ka++;

      // Four channels, 8-bit samples, slower SCLK.
      n = 0;
      @(negedge clk);
      b_valid = 1'b1;
      b_data  = 32'h00FF0000;
      b_pd    = 2'b00;
      while (!b_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      t = cyc;
      @(negedge clk);
      b_valid = 1'b0;
      wait_done("b_done_timeout", 1);
      check("b_ch0", b_cap[0], 32'h0000);
      check("b_ch1", b_cap[1], 32'h0000);
      check("b_ch2", b_cap[2], 32'h0FF0);
      check("b_ch3", b_cap[3], 32'h0000);
      check("b_nsync_low", b_low, 32'd96);
      check("b_half_period", b_first, 32'd3);
      check("b_done_latency", b_done_cyc - t, 32'd99);

      // Fastest SCLK, no gap, two samples back-to-back.
      c_d[0] = 24'hFFF801;  c_p[0] = 2'b00;
      c_d[1] = 24'h7FF000;  c_p[1] = 2'b11;
      kc = c_nfrm;
      i = 0;
      n = 0;
      @(negedge clk);
      c_valid = 1'b1;
      while (i < 2 && n < 200) begin
         if (c_ready) begin
            c_data = c_d[i];
            c_pd   = c_p[i];
            acc[i] = cyc;
            i++;
         end else begin
            c_data = 24'hFFFFFF;
            c_pd   = 2'b10;
         end
         @(negedge clk);
         n++;
      end
      c_valid = 1'b0;
      check("c_accept_timeout", 32'(i), 32'd2);
      wait_done("c_done_timeout", 2);
      check("c_period", acc[1] - acc[0], 32'd33);
      check("c_done_latency", c_done_cyc - acc[1], 32'd33);
      check("c_frame_0", c_frm[kc], 32'h0FFF0801);
      check("c_frame_1", c_frm[kc+1], 32'h37FF3000);
      check("c_nsync_low", c_low, 32'd32);
      check("c_half_period", c_first, 32'd1);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
